// File: rtl/keylock_pkg.sv
// keylock_pkg: shared state encoding, key constants and counter sizing for the keylock engine
package keylock_pkg;
   typedef enum logic [2:0] {LOCKED, OPEN, PROG_NEW, PROG_CONFIRM, LOCKOUT} kl_state_e;
   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/digit_shift_buffer.sv
// digit_shift_buffer: BCD entry register that shifts digits in at the LSB and tracks count and overflow
module digit_shift_buffer #(
   parameter int DIGITS = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  shift_i,
   input  logic [3:0]            digit_i,
   output logic [DIGITS*4-1:0]   code_o,
   output logic [3:0]            digit_cnt_o,
   output logic                  overflow_o
);
   logic [DIGITS*4-1:0] code_q;
   logic [DIGITS*4+3:0] shifted;
   logic [3:0]          cnt_q;
   logic                ovf_q;
   assign shifted     = {code_q, digit_i};
   assign code_o      = code_q;
   assign digit_cnt_o = cnt_q;
   assign overflow_o  = ovf_q;
   // clear wins; a digit past a full buffer drops the oldest one and flags overflow
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         code_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else if (clr_i) begin
         code_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else if (shift_i) begin
         code_q <= shifted[DIGITS*4-1:0];
         cnt_q  <= (cnt_q == 4'(DIGITS)) ? cnt_q : cnt_q + 1'b1;
         ovf_q  <= ovf_q || (cnt_q == 4'(DIGITS));
      end
   end
endmodule

// File: rtl/keylock_engine.sv
// keylock_engine: code entry, master/user compare, user-code reprogramming and failure lockout
module keylock_engine import keylock_pkg::*; #(
   parameter int                  DIGITS         = 6,
   parameter logic [DIGITS*4-1:0] MASTER_CODE    = 24'h555116,
   parameter logic [DIGITS*4-1:0] DEFAULT_UC     = 24'h666666,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  LOCKOUT_CYCLES = 36000000,
   parameter int                  TIMEOUT_CYCLES = 60000000
) (
   input  logic                           hwclk,
   input  logic                           resetN,
   input  logic [3:0]                     key,
   input  logic                           key_valid,
   output logic                           locked,
   output logic                           open,
   output logic                           prog,
   output logic                           lockout,
   output logic                           ok_pulse,
   output logic                           err_pulse,
   output logic [cnt_w(MAX_FAIL+1)-1:0]   fail_cnt,
   output logic [3:0]                     digit_cnt
);
   localparam int FW = cnt_w(MAX_FAIL + 1);
   localparam int LW = cnt_w(LOCKOUT_CYCLES);
   localparam int TW = cnt_w(TIMEOUT_CYCLES);
   kl_state_e           st_q, st_d;
   logic [FW-1:0]       fail_q, fail_d, fail_p1;
   logic [LW-1:0]       lo_q, lo_d;
   logic [TW-1:0]       to_q, to_d;
   logic [DIGITS*4-1:0] uc_q, uc_d, cand_q, cand_d, code;
   logic                ok_q, ok_d, err_q, err_d;
   logic                buf_clr, buf_shift, ovf;
   logic                is_star, is_hash, is_dig, timed, expire, wf, hit_m, hit_u, hit_c;
   digit_shift_buffer #(.DIGITS(DIGITS)) u_buf (
      .clk_i      (hwclk),
      .rst_ni     (resetN),
      .clr_i      (buf_clr),
      .shift_i    (buf_shift),
      .digit_i    (key),
      .code_o     (code),
      .digit_cnt_o(digit_cnt),
      .overflow_o (ovf)
   );
   assign is_star = key_valid && key == KEY_STAR;
   assign is_hash = key_valid && key == KEY_HASH;
   assign is_dig  = key_valid && key <= 4'd9;
   assign timed   = st_q == LOCKED || st_q == PROG_NEW || st_q == PROG_CONFIRM;
   assign expire  = timed && !key_valid && to_q == '0;
   assign wf      = digit_cnt == 4'(DIGITS) && !ovf;
   assign hit_m   = wf && code == MASTER_CODE;
   assign hit_u   = wf && code == uc_q;
   assign hit_c   = wf && code == cand_q;
   assign fail_p1 = fail_q + 1'b1;
   assign locked    = st_q == LOCKED || st_q == LOCKOUT;
   assign open      = st_q == OPEN;
   assign prog      = st_q == PROG_NEW || st_q == PROG_CONFIRM;
   assign lockout   = st_q == LOCKOUT;
   assign ok_pulse  = ok_q;
   assign err_pulse = err_q;
   assign fail_cnt  = fail_q;
   // state register
   always_ff @(posedge hwclk or negedge resetN) begin
      if (!resetN) st_q <= LOCKED;
      else         st_q <= st_d;
   end
   // next state: master beats user on submit, keys beat inactivity expiry
   always_comb begin
      st_d = st_q;
      unique case (st_q)
         LOCKED:       if (is_hash) st_d = hit_m ? PROG_NEW : hit_u ? OPEN :
                                           (fail_p1 == FW'(MAX_FAIL)) ? LOCKOUT : LOCKED;
         OPEN:         if (is_star) st_d = LOCKED;
         PROG_NEW:     if (is_star || expire || (is_hash && !wf)) st_d = LOCKED;
                       else if (is_hash) st_d = PROG_CONFIRM;
         PROG_CONFIRM: if (is_star || is_hash || expire) st_d = LOCKED;
         LOCKOUT:      if (lo_q == '0) st_d = LOCKED;
         default:      st_d = LOCKED;
      endcase
   end
   // pulses, counters, code registers and buffer control; a submit always consumes the entry
   always_comb begin
      ok_d      = is_hash && ((st_q == LOCKED && !hit_m && hit_u) || (st_q == PROG_CONFIRM && hit_c));
      err_d     = is_hash && ((st_q == LOCKED && !hit_m && !hit_u) || (st_q == PROG_NEW && !wf) ||
                              (st_q == PROG_CONFIRM && !hit_c));
      fail_d    = (st_q == LOCKED && is_hash) ? ((hit_m || hit_u) ? '0 : fail_p1) :
                  (st_q == LOCKOUT && lo_q == '0) ? '0 : fail_q;
      cand_d    = (st_q == PROG_NEW && is_hash && wf) ? code : cand_q;
      uc_d      = (st_q == PROG_CONFIRM && is_hash && hit_c) ? cand_q : uc_q;
      lo_d      = (st_q != LOCKOUT) ? LW'(LOCKOUT_CYCLES - 1) : (lo_q == '0) ? lo_q : lo_q - 1'b1;
      to_d      = (key_valid || !timed || expire) ? TW'(TIMEOUT_CYCLES - 1) : to_q - 1'b1;
      buf_clr   = is_star || is_hash || expire || st_d != st_q;
      buf_shift = is_dig && timed;
   end
   // datapath registers; user code is volatile and reverts on reset
   always_ff @(posedge hwclk or negedge resetN) begin
      if (!resetN) begin
         fail_q <= '0;
         lo_q   <= LW'(LOCKOUT_CYCLES - 1);
         to_q   <= TW'(TIMEOUT_CYCLES - 1);
         uc_q   <= DEFAULT_UC;
         cand_q <= '0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         fail_q <= fail_d;
         lo_q   <= lo_d;
         to_q   <= to_d;
         uc_q   <= uc_d;
         cand_q <= cand_d;
         ok_q   <= ok_d;
         err_q  <= err_d;
      end
   end
endmodule

// File: doc/keylock_engine.md
# keylock_engine

Parametrised keylock controller: consumes debounced single-cycle key strobes from the keypad scanner, assembles multi-digit codes, checks them against a master and a user code, supports user-code reprogramming with confirmation, and enforces a lockout after repeated failures. Sits between the keypad scanner and the LED/pattern drivers, replacing the hard-wired 6-digit compare path with a generalised engine.

## Interface

**Parameters**
- `DIGITS`, 6: code length in digits; 1..8.
- `MASTER_CODE`, 24'h555116: master code, BCD, `DIGITS*4` bits, most significant digit first.
- `DEFAULT_UC`, 24'h666666: user code after reset, BCD.
- `MAX_FAIL`, 3: consecutive failed submissions that trigger lockout; at least 1.
- `LOCKOUT_CYCLES`, 36000000: lockout duration in `hwclk` cycles.
- `TIMEOUT_CYCLES`, 60000000: inactivity time that clears a partial entry.

**Ports**
- `hwclk`, in, 1: clock.
- `resetN`, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `key`, in, 4: key code. 0–9 are digits, 4'hA is `*` (clear/relock), 4'hB is `#` (submit). Other codes are ignored.
- `key_valid`, in, 1: one-cycle strobe qualifying `key`.
- `locked`, out, 1: in LOCKED or LOCKOUT.
- `open`, out, 1: in OPEN.
- `prog`, out, 1: in PROG_NEW or PROG_CONFIRM.
- `lockout`, out, 1: in LOCKOUT.
- `ok_pulse`, out, 1: one cycle; unlock or code change accepted.
- `err_pulse`, out, 1: one cycle; submission rejected.
- `fail_cnt`, out, clog2(MAX_FAIL+1): consecutive failures.
- `digit_cnt`, out, 4: digits held in the entry buffer, saturating at `DIGITS`.

## Operation

- **Entry buffer**
  - A digit shifts into the LSB of a `DIGITS*4` register and increments `digit_cnt`.
  - Once `digit_cnt == DIGITS`, any further digit sets `overflow`; the oldest digit shifts out.
  - A `*` clears the buffer in every entry state.
  - Every state transition clears the buffer and `overflow`.
- **A submission is well-formed** only if `digit_cnt == DIGITS` and `overflow` is clear.
- **States**
  - **LOCKED** (reset state). On `#`:
    - Well-formed and equal to the user code: go to OPEN, pulse `ok_pulse`, set `fail_cnt` to 0.
    - Well-formed and equal to `MASTER_CODE`: go to PROG_NEW, set `fail_cnt` to 0. Master takes precedence if it equals the user code.
    - Otherwise: pulse `err_pulse` and increment `fail_cnt`. If `fail_cnt` reaches `MAX_FAIL`, go to LOCKOUT.
  - **OPEN**: `*` goes to LOCKED. Digits and `#` are ignored.
  - **PROG_NEW**: a well-formed `#` latches the buffer into `cand` and goes to PROG_CONFIRM. An ill-formed `#` pulses `err_pulse` and goes to LOCKED. `*` aborts to LOCKED.
  - **PROG_CONFIRM**:
    - A well-formed `#` with buffer equal to `cand` writes the user code, pulses `ok_pulse` and goes to LOCKED.
    - Any other `#` pulses `err_pulse` and goes to LOCKED; the user code is unchanged.
    - `*` aborts to LOCKED.
    - Failures in PROG states do not touch `fail_cnt`.
  - **LOCKOUT**: all keys are ignored. The counter loads `LOCKOUT_CYCLES-1` on entry and counts down. At 0 it goes to LOCKED and clears `fail_cnt`.
- **Inactivity timer**
  - Runs in LOCKED, PROG_NEW and PROG_CONFIRM; reloads on every `key_valid`.
  - Expiry clears the buffer.
  - In PROG states, expiry also returns to LOCKED with no error pulse.
- **Reset**: the user code returns to `DEFAULT_UC` (volatile storage).

## Timing

- **Reset values**: `locked`=1; `open`, `prog`, `lockout`, `ok_pulse`, `err_pulse`=0; `fail_cnt`=0; `digit_cnt`=0.
- **Latency**: `key_valid` in cycle N produces the state change, pulses and `digit_cnt` update registered at N+1. All outputs are registered.
- **Key rate**: back-to-back strobes are accepted every cycle.
- **Simultaneous events**: a key wins over timeout expiry in the same cycle. Lockout expiry and a strobe in the same cycle: the strobe is ignored.
- **Reset mid-operation**: asserting `resetN` low forces all state asynchronously to reset values, whatever the current state (including PROG_CONFIRM and LOCKOUT).
- **Counter widths**: sized by clog2 of their parameters; no wrap-around (count down to 0, then hold).

## Structure

- **`keylock_pkg`**: state enum (LOCKED, OPEN, PROG_NEW, PROG_CONFIRM, LOCKOUT), key constants `KEY_STAR`=4'hA and `KEY_HASH`=4'hB, and a function for counter width.
- **Sub-module `digit_shift_buffer`**: parametrised by `DIGITS`. Provides shift, clear, `digit_cnt` and `overflow`.
- **Top-level FSM**: the FSM, timers and code registers live in `keylock_engine`.

## Test plan

Bench uses `DIGITS`=6, `LOCKOUT_CYCLES`=100, `TIMEOUT_CYCLES`=50.

- **Unlock**: keys 6,6,6,6,6,6,`#` → `ok_pulse` 1 cycle after `#`, `open`=1, `fail_cnt`=0. Then `*` → `locked`=1.
- **Lockout**: three wrong submissions (1,2,3,4,5,6,`#`) → `err_pulse` ×3, `lockout`=1 after the third. Correct code during lockout is ignored. After 100 cycles → `locked`, `fail_cnt`=0.
- **Reprogram**: 5,5,5,1,1,6,`#` → `prog`=1. Then 1,2,3,4,5,6,`#` entered twice → `ok_pulse`, LOCKED. Old code 666666 is rejected; 123456 opens.
- **Confirm mismatch**: in PROG_CONFIRM enter 1,2,3,4,5,7,`#` → `err_pulse`, LOCKED, user code still 666666.
- **Length errors**: 7 digits then `#` → `err_pulse`, `fail_cnt`=1. 5 digits then `#` → `err_pulse`, `fail_cnt`=2.
- **Timeout and reset**: 3 digits then 50 idle cycles → `digit_cnt`=0. `resetN` pulsed low in PROG_CONFIRM → all outputs at reset values, user code back to 666666.
